euc_core_sched: RTL and testbench
=================================

Name: euc_core_sched

Overview:
- Round-robin scheduler that shares one HLS-generated eucHW core (ap_ctrl_hs: ap_start/ap_ready/ap_done/ap_return) between N_REQ requesters.
- Grants one job at a time, steers the operand mux via core_sel, and drives ap_start with the ap_ctrl_hs handshake.
- Captures ap_return on ap_done, returns it to the granted requester, and enforces a watchdog timeout.
- Sits between requester front-ends and the eucHW instance.

Parameters:
N_REQ, 2, number of requesters (2..8)
DATA_W, 32, width of ap_return / rsp_data
TO_W, 16, width of watchdog counter
TIMEOUT, 1024, cycles allowed from start acceptance to ap_done (1..2^TO_W-1)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  N_REQ  per-requester job request, held until accepted
req_ready  out  N_REQ  one-hot, 1-cycle acceptance pulse
core_sel  out  $clog2(N_REQ)  operand-mux select, valid while busy=1
ap_start  out  1  core start
ap_ready  in  1  core accepted inputs
ap_done  in  1  1-cycle completion pulse
ap_return  in  DATA_W  result, valid with ap_done
rsp_valid  out  N_REQ  one-hot response valid
rsp_ready  in  N_REQ  per-requester response accept
rsp_data  out  DATA_W  captured result (0 on timeout)
rsp_err  out  1  1 = watchdog timeout, qualifies rsp_valid
busy  out  1  job in flight (ARB..RESP)

Behaviour:
- Reset (reset=0, async) → all outputs 0; state IDLE; rr pointer = N_REQ-1, so requester 0 has first priority; watchdog 0.
- IDLE:
  - If any req_valid, pick the first set bit searching from ptr+1 (mod N_REQ).
  - Register core_sel=winner, ptr=winner, pulse req_ready[winner] for 1 cycle, then go to START.
- START:
  - ap_start=1 until ap_ready=1 is sampled; ap_start drops the next cycle. Then go to RUN.
  - If ap_done=1 in the same cycle as ap_ready, capture ap_return and go directly to RESP.
- RUN:
  - Watchdog increments each cycle from acceptance.
  - On ap_done: capture ap_return → rsp_data, rsp_err=0, go to RESP.
  - On watchdog==TIMEOUT-1 without ap_done: rsp_data=0, rsp_err=1, go to RESP, and set flag drain=1.
  - ap_done and timeout in the same cycle → ap_done wins, no error.
- RESP:
  - rsp_valid[core_sel]=1, rsp_data and rsp_err held stable until rsp_ready[core_sel]=1.
  - On accept: if drain=0, go to IDLE; else go to FLUSH.
  - rsp_ready on a non-granted index is ignored.
- FLUSH:
  - Wait for the late ap_done and discard ap_return; no ap_start is issued. Then go to IDLE, drain=0.
  - A late ap_done arriving during RESP is recorded and skips FLUSH.
- Latency: request to ap_start = 1 cycle; ap_done to rsp_valid = 1 cycle. Minimum back-to-back job spacing = core latency + 3 cycles.
- Deasserting req_valid before acceptance withdraws the request; no grant is made.
- Only the granted requester has its req_ready pulsed; others wait. Fairness: with all requesters active, each is granted once per N_REQ jobs.
- busy=1 in START/RUN/RESP/FLUSH; core_sel is held constant for the whole job.
- Reset mid-job: immediate return to IDLE, ap_start=0. External logic must also reset the core.

Optional Feature:
- Macro EUC_SCHED_PERF_EN.
- Defined: adds outputs perf_jobs (32 bits, count of completed non-error jobs) and perf_last_lat (TO_W bits, watchdog value at the last ap_done). Both reset to 0 and are updated on the RUN→RESP transition. perf_jobs wraps at 2^32.
- Undefined: these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Package euc_sched_pkg holds:
  - state_e enum {IDLE, START, RUN, RESP, FLUSH}
  - localparam DEF_TIMEOUT
  - function rr_next(ptr, req) used by the arbiter and by the bench reference model.
- Sub-module euc_rr_pick: combinational round-robin picker; inputs req and ptr, outputs winner index and any flag.
- FSM, watchdog and capture registers stay in euc_core_sched.

Test Plan:
- Single job: req_valid[0]=1; core asserts ap_ready 2 cycles after ap_start, ap_done 9 cycles later with ap_return=0x0000_1234 → req_ready[0] pulses once, rsp_valid[0]=1 with rsp_data=0x1234, rsp_err=0.
- Fairness: N_REQ=2, both req_valid held high for 6 jobs → grant order 0,1,0,1,0,1; core_sel matches each rsp_valid index.
- Timeout: TIMEOUT=16, core never pulses ap_done → rsp_valid at cycle 16 after acceptance with rsp_err=1, rsp_data=0. A later ap_done with ap_return=0xDEAD is discarded, then IDLE; the next request is granted normally.
- Backpressure: rsp_ready[1]=0 for 20 cycles → rsp_valid[1] and rsp_data stay stable; no new ap_start until accept; req_valid[0] is not accepted meanwhile.
- Corner: ap_ready and ap_done high in the same cycle with ap_return=7 → direct START→RESP, rsp_data=7. Also ap_done at watchdog==TIMEOUT-1 → rsp_err=0.
- Async reset asserted during RUN → all outputs 0 immediately; after release, requester 0 has priority.

Source files
------------

// File: rtl/euc_sched_pkg.sv
// euc_sched_pkg: shared types, defaults and the round-robin helper for the eucHW scheduler.
package euc_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    RESP  = 3'd3,
    FLUSH = 3'd4
  } state_e;

  localparam int unsigned DEF_TIMEOUT = 1024;
  localparam int unsigned MAX_REQ     = 8;
  localparam int unsigned IDX_W       = 3;

  // First set bit of req searching from ptr+1 upward, wrapping at n; returns ptr when req is empty.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] ptr,
                                               input logic [MAX_REQ-1:0] req,
                                               input int unsigned n);
    logic [IDX_W-1:0] win;
    int               idx;
    win = ptr;
    for (int k = int'(MAX_REQ); k >= 1; k--) begin
      if (k <= int'(n)) begin
        idx = int'(ptr) + k;
        if (idx >= int'(n)) idx = idx - int'(n);
        if (req[IDX_W'(idx)]) win = IDX_W'(idx);
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/euc_rr_pick.sv
// euc_rr_pick: combinational round-robin picker over N_REQ request lines.
module euc_rr_pick
  import euc_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  localparam int unsigned SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic [MAX_REQ-1:0] req_pad;

  // Widen the request vector and search from the slot after the last grant.
  always_comb begin
    req_pad            = '0;
    req_pad[N_REQ-1:0] = req;
    winner             = SEL_W'(rr_next(IDX_W'(ptr), req_pad, N_REQ));
    any                = |req;
  end

endmodule

// File: rtl/euc_core_sched.sv
// euc_core_sched: round-robin sharing of one ap_ctrl_hs eucHW core with watchdog.
// Optional performance counters are enabled by defining EUC_SCHED_PERF_EN.
module euc_core_sched
  import euc_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TO_W    = 16,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  localparam int unsigned SEL_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_REQ-1:0]  req_valid,
  output logic [N_REQ-1:0]  req_ready,
  output logic [SEL_W-1:0]  core_sel,
  output logic              ap_start,
  input  logic              ap_ready,
  input  logic              ap_done,
  input  logic [DATA_W-1:0] ap_return,
  output logic [N_REQ-1:0]  rsp_valid,
  input  logic [N_REQ-1:0]  rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy
`ifdef EUC_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_jobs,
  output logic [TO_W-1:0]   perf_last_lat
`endif
);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d, core_sel_d, pick_winner;
  logic              pick_any;
  logic [TO_W-1:0]   wd_q, wd_d;
  logic              drain_q, drain_d;
  logic [N_REQ-1:0]  req_ready_d, rsp_valid_d, sel_oh;
  logic              ap_start_d, rsp_err_d, busy_d;
  logic [DATA_W-1:0] rsp_data_d;
  logic              wd_expire, rsp_accept;

  euc_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req_valid),
    .ptr    (ptr_q),
    .winner (pick_winner),
    .any    (pick_any)
  );

  assign sel_oh     = N_REQ'(1) << core_sel;
  assign rsp_accept = |(rsp_ready & sel_oh);
  assign wd_expire  = (wd_q == TO_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode; ap_done has priority over the watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (pick_any) state_d = START;
      START: if (ap_ready) state_d = ap_done ? RESP : RUN;
      RUN:   if (ap_done || wd_expire) state_d = RESP;
      RESP:  if (rsp_accept) state_d = (drain_q && !ap_done) ? FLUSH : IDLE;
      FLUSH: if (ap_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, watchdog and drain flag.
  always_comb begin
    req_ready_d = '0;
    ap_start_d  = ap_start;
    core_sel_d  = core_sel;
    ptr_d       = ptr_q;
    wd_d        = wd_q;
    drain_d     = drain_q;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;
    rsp_err_d   = rsp_err;
    busy_d      = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          req_ready_d = N_REQ'(1) << pick_winner;
          core_sel_d  = pick_winner;
          ptr_d       = pick_winner;
          ap_start_d  = 1'b1;
        end
      end
      START: begin
        if (ap_ready) begin
          ap_start_d = 1'b0;
          wd_d       = '0;
          if (ap_done) begin
            rsp_data_d  = ap_return;
            rsp_err_d   = 1'b0;
            rsp_valid_d = sel_oh;
          end
        end
      end
      RUN: begin
        if (ap_done) begin
          rsp_data_d  = ap_return;
          rsp_err_d   = 1'b0;
          rsp_valid_d = sel_oh;
        end else if (wd_expire) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = sel_oh;
          drain_d     = 1'b1;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      RESP: begin
        if (ap_done) drain_d = 1'b0;
        if (rsp_accept) rsp_valid_d = '0;
      end
      FLUSH: begin
        if (ap_done) drain_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_ready <= '0;
      ap_start  <= 1'b0;
      core_sel  <= '0;
      ptr_q     <= SEL_W'(N_REQ - 1);
      wd_q      <= '0;
      drain_q   <= 1'b0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      req_ready <= req_ready_d;
      ap_start  <= ap_start_d;
      core_sel  <= core_sel_d;
      ptr_q     <= ptr_d;
      wd_q      <= wd_d;
      drain_q   <= drain_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
      busy      <= busy_d;
    end
  end

`ifdef EUC_SCHED_PERF_EN
  logic perf_hit;
  assign perf_hit = ap_done && ((state_q == RUN) || ((state_q == START) && ap_ready));

  // Completed-job counter and latency of the most recent completion.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_jobs     <= '0;
      perf_last_lat <= '0;
    end else if (perf_hit) begin
      perf_jobs     <= perf_jobs + 32'd1;
      perf_last_lat <= (state_q == RUN) ? wd_q : '0;
    end
  end
`endif

endmodule

// File: tb/tb_euc_core_sched.sv
// tb_euc_core_sched: directed self-checking bench for euc_core_sched (N_REQ=2, TIMEOUT=16).
module tb_euc_core_sched;

  logic        clock;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [0:0]  core_sel;
  logic        ap_start;
  logic        ap_ready;
  logic        ap_done;
  logic [31:0] ap_return;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  euc_core_sched #(.N_REQ(2), .DATA_W(32), .TO_W(16), .TIMEOUT(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .core_sel  (core_sel),
    .ap_start  (ap_start),
    .ap_ready  (ap_ready),
    .ap_done   (ap_done),
    .ap_return (ap_return),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    n_checks++;
    if ({req_ready, core_sel, ap_start, rsp_valid, rsp_data, rsp_err, busy} !== 40'd0)
      $display("FAIL reset_outputs: got rr=%b sel=%b st=%b rv=%b rd=%h re=%b bz=%b expected all 0",
               req_ready, core_sel, ap_start, rsp_valid, rsp_data, rsp_err, busy);
    else n_pass++;
    reset = 1'b1;
    step();
    n_checks++;
    if ({req_ready, ap_start, busy} !== 4'b0000)
      $display("FAIL reset_idle: got rr=%b st=%b bz=%b expected 0 0 0", req_ready, ap_start, busy);
    else n_pass++;
  endtask

  task automatic test_single();
    bit ok;
    req_valid = 2'b01;
    step();
    n_checks++;
    if ({req_ready, ap_start, busy, core_sel} !== 5'b01110)
      $display("FAIL single_grant: got %b expected 01110", {req_ready, ap_start, busy, core_sel});
    else n_pass++;
    req_valid = 2'b00;
    step();
    n_checks++;
    if ({req_ready, ap_start} !== 3'b001)
      $display("FAIL single_pulse: got %b expected 001", {req_ready, ap_start});
    else n_pass++;
    step();
    ap_ready = 1'b1;
    step();
    ap_ready = 1'b0;
    n_checks++;
    if ({ap_start, busy, rsp_valid} !== 4'b0100)
      $display("FAIL single_accept: got %b expected 0100", {ap_start, busy, rsp_valid});
    else n_pass++;
    ok = 1'b1;
    repeat (8) begin
      step();
      if (rsp_valid !== 2'b00 || ap_start !== 1'b0) ok = 1'b0;
    end
    n_checks++;
    if (ok !== 1'b1) $display("FAIL single_wait: got early rsp/start expected none");
    else n_pass++;
    ap_done = 1'b1; ap_return = 32'h0000_1234;
    step();
    ap_done = 1'b0; ap_return = 32'h0;
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {2'b01, 1'b0, 32'h0000_1234})
      $display("FAIL single_rsp: got rv=%b re=%b rd=%h expected 01 0 00001234", rsp_valid, rsp_err, rsp_data);
    else n_pass++;
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    n_checks++;
    if ({rsp_valid, busy} !== 3'b000)
      $display("FAIL single_done: got rv=%b bz=%b expected 00 0", rsp_valid, busy);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok;
    req_valid = 2'b10;
    step();
    n_checks++;
    if ({req_ready, core_sel} !== 3'b101)
      $display("FAIL bp_grant1: got rr=%b sel=%b expected 10 1", req_ready, core_sel);
    else n_pass++;
    req_valid = 2'b01; ap_ready = 1'b1;
    step();
    ap_ready = 1'b0; ap_done = 1'b1; ap_return = 32'hCAFE_0001;
    step();
    ap_done = 1'b0; ap_return = 32'hFFFF_FFFF; rsp_ready = 2'b01;
    ok = 1'b1;
    repeat (20) begin
      if ({rsp_valid, rsp_data, rsp_err, ap_start, req_ready} !== {2'b10, 32'hCAFE_0001, 1'b0, 1'b0, 2'b00})
        ok = 1'b0;
      step();
    end
    n_checks++;
    if (ok !== 1'b1)
      $display("FAIL bp_hold: got rv=%b rd=%h st=%b rr=%b expected stable 10 cafe0001 0 00",
               rsp_valid, rsp_data, ap_start, req_ready);
    else n_pass++;
    rsp_ready = 2'b10;
    step();
    rsp_ready = 2'b00;
    n_checks++;
    if ({rsp_valid, req_ready} !== 4'b0000)
      $display("FAIL bp_accept: got rv=%b rr=%b expected 00 00", rsp_valid, req_ready);
    else n_pass++;
    step();
    n_checks++;
    if ({req_ready, core_sel, ap_start} !== 4'b0101)
      $display("FAIL bp_grant0: got rr=%b sel=%b st=%b expected 01 0 1", req_ready, core_sel, ap_start);
    else n_pass++;
    req_valid = 2'b00; ap_ready = 1'b1; ap_done = 1'b1; ap_return = 32'd9;
    step();
    ap_ready = 1'b0; ap_done = 1'b0;
    n_checks++;
    if ({rsp_valid, rsp_data} !== {2'b01, 32'd9})
      $display("FAIL bp_job0: got rv=%b rd=%h expected 01 00000009", rsp_valid, rsp_data);
    else n_pass++;
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
  endtask

  task automatic test_timeout();
    bit ok;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00; ap_ready = 1'b1;
    step();
    ap_ready = 1'b0;
    ok = 1'b1;
    repeat (15) begin
      step();
      if (rsp_valid !== 2'b00) ok = 1'b0;
    end
    n_checks++;
    if (ok !== 1'b1) $display("FAIL to_early: got rsp before cycle 16 expected none");
    else n_pass++;
    step();
    n_checks++;
    if ({rsp_valid, rsp_err, busy, rsp_data} !== {2'b01, 1'b1, 1'b1, 32'h0})
      $display("FAIL to_rsp: got rv=%b re=%b bz=%b rd=%h expected 01 1 1 0", rsp_valid, rsp_err, busy, rsp_data);
    else n_pass++;
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    n_checks++;
    if ({rsp_valid, busy} !== 3'b001)
      $display("FAIL to_flush: got rv=%b bz=%b expected 00 1", rsp_valid, busy);
    else n_pass++;
    req_valid = 2'b01;
    ok = 1'b1;
    repeat (3) begin
      step();
      if (req_ready !== 2'b00 || ap_start !== 1'b0) ok = 1'b0;
    end
    n_checks++;
    if (ok !== 1'b1) $display("FAIL to_no_grant: got grant/start during flush expected none");
    else n_pass++;
    ap_done = 1'b1; ap_return = 32'h0000_DEAD;
    step();
    ap_done = 1'b0; ap_return = 32'h0;
    n_checks++;
    if ({rsp_valid, busy, rsp_data} !== {2'b00, 1'b0, 32'h0})
      $display("FAIL to_discard: got rv=%b bz=%b rd=%h expected 00 0 0", rsp_valid, busy, rsp_data);
    else n_pass++;
    step();
    n_checks++;
    if ({req_ready, ap_start} !== 3'b011)
      $display("FAIL to_regrant: got rr=%b st=%b expected 01 1", req_ready, ap_start);
    else n_pass++;
    req_valid = 2'b00; ap_ready = 1'b1;
    step();
    ap_ready = 1'b0; ap_done = 1'b1; ap_return = 32'h55;
    step();
    ap_done = 1'b0;
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {2'b01, 1'b0, 32'h55})
      $display("FAIL to_next_job: got rv=%b re=%b rd=%h expected 01 0 55", rsp_valid, rsp_err, rsp_data);
    else n_pass++;
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
  endtask

  task automatic test_corner();
    req_valid = 2'b01;
    step();
    req_valid = 2'b00; ap_ready = 1'b1; ap_done = 1'b1; ap_return = 32'd7;
    step();
    ap_ready = 1'b0; ap_done = 1'b0; ap_return = 32'h0;
    n_checks++;
    if ({rsp_valid, rsp_err, ap_start, rsp_data} !== {2'b01, 1'b0, 1'b0, 32'd7})
      $display("FAIL corner_same_cycle: got rv=%b re=%b st=%b rd=%h expected 01 0 0 7",
               rsp_valid, rsp_err, ap_start, rsp_data);
    else n_pass++;
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    req_valid = 2'b10;
    step();
    req_valid = 2'b00; ap_ready = 1'b1;
    step();
    ap_ready = 1'b0;
    repeat (15) step();
    ap_done = 1'b1; ap_return = 32'h0000_ABCD;
    step();
    ap_done = 1'b0; ap_return = 32'h0;
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 1'b0, 32'h0000_ABCD})
      $display("FAIL corner_done_at_limit: got rv=%b re=%b rd=%h expected 10 0 abcd", rsp_valid, rsp_err, rsp_data);
    else n_pass++;
    rsp_ready = 2'b10;
    step();
    rsp_ready = 2'b00;
    n_checks++;
    if ({rsp_valid, busy} !== 3'b000)
      $display("FAIL corner_no_flush: got rv=%b bz=%b expected 00 0", rsp_valid, busy);
    else n_pass++;
  endtask

  task automatic test_fairness();
    logic [1:0] exp_oh;
    logic       exp_sel;
    reset = 1'b0;
    step();
    reset = 1'b1;
    req_valid = 2'b11;
    for (int j = 0; j < 6; j++) begin
      exp_sel = (j % 2 == 1);
      exp_oh  = exp_sel ? 2'b10 : 2'b01;
      step();
      n_checks++;
      if ({req_ready, core_sel} !== {exp_oh, exp_sel})
        $display("FAIL fair_grant%0d: got rr=%b sel=%b expected %b %b", j, req_ready, core_sel, exp_oh, exp_sel);
      else n_pass++;
      ap_ready = 1'b1;
      step();
      ap_ready = 1'b0; ap_done = 1'b1; ap_return = 32'h100 + 32'(j);
      step();
      ap_done = 1'b0;
      n_checks++;
      if ({rsp_valid, core_sel, rsp_data} !== {exp_oh, exp_sel, 32'h100 + 32'(j)})
        $display("FAIL fair_rsp%0d: got rv=%b sel=%b rd=%h expected %b %b %h",
                 j, rsp_valid, core_sel, rsp_data, exp_oh, exp_sel, 32'h100 + 32'(j));
      else n_pass++;
      rsp_ready = 2'b11;
      step();
      rsp_ready = 2'b00;
    end
    req_valid = 2'b00;
    step();
  endtask

  task automatic test_async_reset();
    req_valid = 2'b01;
    step();
    req_valid = 2'b00; ap_ready = 1'b1;
    step();
    ap_ready = 1'b0;
    step();
    step();
    n_checks++;
    if ({busy, ap_start, core_sel} !== 3'b100)
      $display("FAIL areset_pre: got bz=%b st=%b sel=%b expected 1 0 0", busy, ap_start, core_sel);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, core_sel, ap_start, rsp_valid, rsp_data, rsp_err, busy} !== 40'd0)
      $display("FAIL areset_outputs: got rr=%b sel=%b st=%b rv=%b rd=%h re=%b bz=%b expected all 0",
               req_ready, core_sel, ap_start, rsp_valid, rsp_data, rsp_err, busy);
    else n_pass++;
    step();
    step();
    reset = 1'b1;
    req_valid = 2'b11;
    step();
    n_checks++;
    if ({req_ready, core_sel, ap_start} !== 4'b0101)
      $display("FAIL areset_priority: got rr=%b sel=%b st=%b expected 01 0 1", req_ready, core_sel, ap_start);
    else n_pass++;
    req_valid = 2'b00;
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 2'b00;
    ap_ready  = 1'b0;
    ap_done   = 1'b0;
    ap_return = 32'h0;
    rsp_ready = 2'b00;
    test_reset();
    test_single();
    test_backpressure();
    test_timeout();
    test_corner();
    test_fairness();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
